scroll_display: RTL and testbench
=================================

SCROLL_DISPLAY -- requirements
Module: scroll_display

Interface
REQ-001 The block SHALL have the parameter NUM_DIGITS, default 4, meaning the number of display digits.
REQ-002 The block SHALL have the parameter CODE_W, default 4, meaning the width of one digit code.
REQ-003 The block SHALL have the parameter MSG_MAX, default 16, meaning the message buffer depth; NUM_DIGITS <= MSG_MAX.
REQ-004 The block SHALL have the parameter TICK_DIV, default 50000000, meaning the number of clocks per scroll step (>= 1).
REQ-005 The block SHALL have the parameter BLANK, default all-ones, meaning the code shown for an unlit digit.
REQ-006 Derived widths SHALL be ADDR_W = clog2(MSG_MAX) and LEN_W = clog2(MSG_MAX+1).
REQ-007 The block SHALL use one clock and a synchronous, active-high reset, with ports as follows.
 - clk  input  1  clock.
 - rst  input  1  synchronous, active-high reset.
 - start  input  1  restart pulse.
 - pause  input  1  level; freezes stepping.
 - dir  input  1  0 = scroll left (pos+1), 1 = scroll right (pos-1).
 - oneshot  input  1  stop after one full pass; sampled at start.
 - msg_len  input  LEN_W  active message length; sampled at start.
 - wr_en  input  1  message write strobe.
 - wr_addr  input  ADDR_W  write index.
 - wr_data  input  CODE_W  write code.
 - digits  output  NUM_DIGITS*CODE_W  digit k occupies [k*CODE_W +: CODE_W]; k=0 is rightmost.
 - step  output  1  high in the cycle a step edge occurs.
 - wrap  output  1  high in a step cycle whose next pos is 0.
 - busy  output  1  high in RUN or HOLD.
 - done  output  1  high in DONE.

Function
REQ-008 The FSM SHALL have the states IDLE, RUN, HOLD, and DONE.
REQ-009 Start SHALL have priority over all other inputs except rst. On start, in any state, the block SHALL set pos=0 and prescaler=0, latch len=clamp(msg_len,1,MSG_MAX), latch oneshot, and go to HOLD if pause=1, otherwise RUN.
REQ-010 In RUN, the prescaler SHALL count 0..TICK_DIV-1. When the count is TICK_DIV-1, step=1, the prescaler SHALL return to 0, and pos SHALL update at that edge. The first step edge SHALL occur TICK_DIV cycles after the start edge.
REQ-011 On a step, pos_next SHALL be (pos+1) mod len if dir=0, or (pos+len-1) mod len if dir=1. dir SHALL be sampled live at each step.
REQ-012 In RUN with pause=1, the FSM SHALL go to HOLD and the prescaler SHALL freeze without stepping. In HOLD with pause=0, the FSM SHALL return to RUN and the prescaler SHALL resume from its frozen value.
REQ-013 When a step has wrap=1 and oneshot is latched, the FSM SHALL go to DONE with pos=0. In DONE, no steps SHALL occur.
REQ-014 In RUN, HOLD, and DONE, digits[k] SHALL equal mem[(pos + NUM_DIGITS-1-k) mod len]. The modulo SHALL be exact for any len >= 1, including len < NUM_DIGITS. In IDLE, all digits SHALL be BLANK.
REQ-015 digits SHALL be a function of registered state, pos, len, and mem only, with no added latency; a pos change SHALL be visible in the cycle after its edge.
REQ-016 When wr_en=1, mem[wr_addr] SHALL be written at the edge. Writes with wr_addr >= MSG_MAX SHALL be ignored. Writes SHALL be allowed in every state, and a write coinciding with a step SHALL have both effects take place.
REQ-017 step and wrap SHALL be 0 outside RUN, when pause=1, and when start=1.

Reset
REQ-018 rst SHALL dominate start, writes, and stepping.
REQ-019 On rst, the block SHALL set state=IDLE, pos=0, prescaler=0, len=MSG_MAX, latched oneshot=0, and every mem entry to BLANK.
REQ-020 In the cycle after reset, outputs SHALL be digits all-BLANK, step=0, wrap=0, busy=0, done=0. A rst asserted mid-RUN SHALL have the same effect.

Structure
REQ-021 The shared package scroll_pkg SHALL hold the FSM state encoding, the default BLANK code, and the default parameter values.
REQ-022 The sub-module tick_prescaler SHALL contain the prescaler (inputs: clr, en; output: tick), parametrised by TICK_DIV.

Verification
The bench SHALL use NUM_DIGITS=4, MSG_MAX=16, TICK_DIV=2, mem[0..4]=1,2,3,4,5, and msg_len=5. Digit values below are written digit3..digit0.
REQ-023 Reset: rst for 1 cycle -> digits=FFFF, busy=0, done=0, no step.
REQ-024 Left loop: start with dir=0, oneshot=0 -> digits 1234 immediately; then every 2 cycles 2345, 3451, 4512, 5123, 1234, with wrap=1 only on the 5th step.
REQ-025 Pause: pause=1 for 6 cycles, 1 cycle after the first step -> digits hold 2345, step=0; after release, the next step occurs exactly 1 cycle later.
REQ-026 Right scroll and one-shot: start with dir=1, oneshot=1 -> 5123, 4512, 3451, 2345, 1234; then done=1 and busy=0 with 1234 held; a later start restarts at 1234 with busy=1.
REQ-027 Short message and reset: msg_len=2 with mem[0..1]=7,8 -> digits 7878; msg_len=0 -> clamped to len=1, digits 7777; rst mid-RUN -> digits FFFF in the next cycle and mem all BLANK.

Source files
------------

// File: rtl/scroll_pkg.sv
// Shared definitions for the scrolling digit display: FSM encoding and default parameters.
package scroll_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HOLD = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam int          DEF_NUM_DIGITS = 4;
   localparam int          DEF_CODE_W     = 4;
   localparam int          DEF_MSG_MAX    = 16;
   localparam int unsigned DEF_TICK_DIV   = 50000000;
   // The blank code is all-ones at whatever CODE_W the instance uses.
   localparam logic        DEF_BLANK_FILL = 1'b1;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: counts enabled cycles 0..TICK_DIV-1 and pulses tick on the last one.
// tick is combinational from the count; clr wins over en and suppresses tick.
module tick_prescaler
   import scroll_pkg::*;
#(
   parameter int unsigned TICK_DIV = DEF_TICK_DIV
) (
   input  logic clk,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int             CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] r_cnt;

   assign tick = en && !clr && (r_cnt == CNT_MAX);

   // Holding the count while en is low lets a paused scroll resume mid-period.
   always_ff @(posedge clk) begin
      if (clr) begin
         r_cnt <= '0;
      end else if (en) begin
         r_cnt <= tick ? '0 : r_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/scroll_display.sv
// Scrolls a message buffer across NUM_DIGITS digit codes, one position per TICK_DIV clocks.
// Supports pause, left/right direction, one-shot pass and live buffer writes.
module scroll_display
   import scroll_pkg::*;
#(
   parameter int                NUM_DIGITS = DEF_NUM_DIGITS,
   parameter int                CODE_W     = DEF_CODE_W,
   parameter int                MSG_MAX    = DEF_MSG_MAX,
   parameter int unsigned       TICK_DIV   = DEF_TICK_DIV,
   parameter logic [CODE_W-1:0] BLANK      = {CODE_W{DEF_BLANK_FILL}},
   localparam int               ADDR_W     = (MSG_MAX > 1) ? $clog2(MSG_MAX) : 1,
   localparam int               LEN_W      = $clog2(MSG_MAX + 1)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic                         pause,
   input  logic                         dir,
   input  logic                         oneshot,
   input  logic [LEN_W-1:0]             msg_len,
   input  logic                         wr_en,
   input  logic [ADDR_W-1:0]            wr_addr,
   input  logic [CODE_W-1:0]            wr_data,
   output logic [NUM_DIGITS*CODE_W-1:0] digits,
   output logic                         step,
   output logic                         wrap,
   output logic                         busy,
   output logic                         done
);

   state_t             r_state;
   logic               r_busy;
   logic               r_done;
   logic               r_oneshot;
   logic [ADDR_W-1:0]  r_pos;
   logic [LEN_W-1:0]   r_len;
   logic [CODE_W-1:0]  r_mem [MSG_MAX];

   logic               w_run_en;
   logic               w_tick;
   logic               w_wrap;
   logic [ADDR_W-1:0]  w_pos_nxt;
   logic [LEN_W-1:0]   w_len_clamp;

   assign w_run_en = (r_state == S_RUN) && !pause;

   tick_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_prescaler (
      .clk  (clk),
      .clr  (rst || start),
      .en   (w_run_en),
      .tick (w_tick)
   );

   // r_pos is always < r_len, so a single compare replaces the modulo here.
   always_comb begin
      w_pos_nxt = r_pos;
      if (!dir) begin
         w_pos_nxt = (int'(r_pos) + 1 >= int'(r_len)) ? '0 : r_pos + ADDR_W'(1);
      end else begin
         w_pos_nxt = (r_pos == '0) ? ADDR_W'(int'(r_len) - 1) : r_pos - ADDR_W'(1);
      end
   end

   assign w_wrap = w_tick && (w_pos_nxt == '0);

   always_comb begin
      w_len_clamp = msg_len;
      if (msg_len == '0) begin
         w_len_clamp = LEN_W'(1);
      end else if (int'(msg_len) > MSG_MAX) begin
         w_len_clamp = LEN_W'(MSG_MAX);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_oneshot <= 1'b0;
         r_pos     <= '0;
         r_len     <= LEN_W'(MSG_MAX);
      end else if (start) begin
         r_state   <= pause ? S_HOLD : S_RUN;
         r_busy    <= 1'b1;
         r_done    <= 1'b0;
         r_oneshot <= oneshot;
         r_pos     <= '0;
         r_len     <= w_len_clamp;
      end else begin
         case (r_state)
            S_RUN: begin
               if (pause) begin
                  r_state <= S_HOLD;
               end else if (w_tick) begin
                  r_pos <= w_pos_nxt;
                  if (w_wrap && r_oneshot) begin
                     r_state <= S_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end
               end
            end
            S_HOLD: begin
               if (!pause) begin
                  r_state <= S_RUN;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < MSG_MAX; i++) begin
            r_mem[i] <= BLANK;
         end
      end else if (wr_en && (int'(wr_addr) < MSG_MAX)) begin
         r_mem[wr_addr] <= wr_data;
      end
   end

   // Full modulo keeps the window correct when the message is shorter than the display.
   always_comb begin
      digits = {NUM_DIGITS{BLANK}};
      if (r_state != S_IDLE) begin
         for (int k = 0; k < NUM_DIGITS; k++) begin
            digits[k*CODE_W +: CODE_W] =
               r_mem[ADDR_W'((int'(r_pos) + NUM_DIGITS - 1 - k) % int'(r_len))];
         end
      end
   end

   assign step = w_tick;
   assign wrap = w_wrap;
   assign busy = r_busy;
   assign done = r_done;

endmodule

// File: tb/tb_scroll_display.sv
// Directed bench for scroll_display: reset, left loop, pause, right one-shot, short messages, mid-run reset.
module tb_scroll_display;

   localparam int ND     = 4;
   localparam int CW     = 4;
   localparam int MM     = 16;
   localparam int ADDR_W = 4;
   localparam int LEN_W  = 5;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 start = 1'b0;
   logic                 pause = 1'b0;
   logic                 dir = 1'b0;
   logic                 oneshot = 1'b0;
   logic [LEN_W-1:0]     msg_len = 5'd5;
   logic                 wr_en = 1'b0;
   logic [ADDR_W-1:0]    wr_addr = '0;
   logic [CW-1:0]        wr_data = '0;
   logic [ND*CW-1:0]     digits;
   logic                 step;
   logic                 wrap;
   logic                 busy;
   logic                 done;

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0] seq_l [5] = '{16'h2345, 16'h3451, 16'h4512, 16'h5123, 16'h1234};
   logic [15:0] seq_r [5] = '{16'h5123, 16'h4512, 16'h3451, 16'h2345, 16'h1234};

   scroll_display #(
      .NUM_DIGITS (ND),
      .CODE_W     (CW),
      .MSG_MAX    (MM),
      .TICK_DIV   (2)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .pause   (pause),
      .dir     (dir),
      .oneshot (oneshot),
      .msg_len (msg_len),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .digits  (digits),
      .step    (step),
      .wrap    (wrap),
      .busy    (busy),
      .done    (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   task automatic write_mem(input logic [ADDR_W-1:0] a, input logic [CW-1:0] d);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      @(negedge clk);
      wr_en   = 1'b0;
   endtask

   task automatic do_start(input logic d, input logic os, input logic [LEN_W-1:0] len);
      dir     = d;
      oneshot = os;
      msg_len = len;
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      #1;
   endtask

   initial begin
      // Reset for one cycle
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_digits", 32'(digits), 32'hFFFF);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_step", 32'(step), 0);

      for (int i = 0; i < 5; i++) write_mem(ADDR_W'(i), CW'(i + 1));
      check("idle_blank", 32'(digits), 32'hFFFF);

      // Left loop
      do_start(1'b0, 1'b0, 5'd5);
      check("left_first", 32'(digits), 32'h1234);
      check("left_busy", 32'(busy), 1);
      for (int i = 0; i < 5; i++) begin
         check("left_nostep", 32'(step), 0);
         @(negedge clk);
         check("left_step", 32'(step), 1);
         check("left_wrap", 32'(wrap), (i == 4) ? 1 : 0);
         @(negedge clk);
         check("left_digits", 32'(digits), 32'(seq_l[i]));
      end

      // Pause one cycle after the first step
      do_start(1'b0, 1'b0, 5'd5);
      @(negedge clk);
      @(negedge clk);
      check("pause_pre", 32'(digits), 32'h2345);
      @(negedge clk);
      pause = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("pause_hold", 32'(digits), 32'h2345);
         check("pause_step", 32'(step), 0);
      end
      pause = 1'b0;
      #1;
      check("release_hold", 32'(step), 0);
      @(negedge clk);
      check("release_step", 32'(step), 1);
      check("release_digits", 32'(digits), 32'h2345);
      @(negedge clk);
      check("release_next", 32'(digits), 32'h3451);

      // Right scroll, one-shot
      do_start(1'b1, 1'b1, 5'd5);
      check("right_first", 32'(digits), 32'h1234);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("right_wrap", 32'(wrap), (i == 4) ? 1 : 0);
         @(negedge clk);
         check("right_digits", 32'(digits), 32'(seq_r[i]));
      end
      check("os_done", 32'(done), 1);
      check("os_busy", 32'(busy), 0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("done_nostep", 32'(step), 0);
         check("done_digits", 32'(digits), 32'h1234);
      end
      do_start(1'b0, 1'b0, 5'd5);
      check("restart_digits", 32'(digits), 32'h1234);
      check("restart_busy", 32'(busy), 1);
      check("restart_done", 32'(done), 0);

      // Short messages
      write_mem(4'd0, 4'd7);
      write_mem(4'd1, 4'd8);
      do_start(1'b0, 1'b0, 5'd2);
      check("len2_digits", 32'(digits), 32'h7878);
      @(negedge clk);
      @(negedge clk);
      check("len2_step", 32'(digits), 32'h8787);
      do_start(1'b0, 1'b0, 5'd0);
      check("len0_digits", 32'(digits), 32'h7777);
      @(negedge clk);
      check("len1_wrap", 32'(wrap), 1);
      @(negedge clk);
      check("len1_hold", 32'(digits), 32'h7777);

      // Reset mid-run
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("midrst_digits", 32'(digits), 32'hFFFF);
      check("midrst_busy", 32'(busy), 0);
      check("midrst_step", 32'(step), 0);
      do_start(1'b0, 1'b0, 5'd16);
      check("mem_blank", 32'(digits), 32'hFFFF);
      check("mem_blank_busy", 32'(busy), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
